// File: rtl/cfi_log_queue.sv
// CFI log queue: a show-ahead circular buffer between the commit stage and the
// CFI checking backend. It counts pushes that are rejected because the queue is
// full, and keeps a sticky overflow flag.

package cfi_log_pkg;

  typedef enum logic [2:0] {
    CFI_CALL     = 3'd0,
    CFI_RET      = 3'd1,
    CFI_JMP_IND  = 3'd2,
    CFI_CALL_IND = 3'd3,
    CFI_BRANCH   = 3'd4
  } cfi_kind_e;

  // One control-flow event as seen at commit.
  typedef struct packed {
    cfi_kind_e   kind;
    logic [31:0] pc;
    logic [31:0] target;
  } cfi_log_t;

endpackage

module cfi_log_queue #(
  parameter int DEPTH    = 8,
  parameter int AF_SLACK = 2,
  parameter int DROP_W   = 16,
  localparam int LOG_W   = $bits(cfi_log_pkg::cfi_log_t),
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [LOG_W-1:0]  log_i,
  input  logic              pop_i,
  output logic [LOG_W-1:0]  log_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [CNT_W-1:0]  usage_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              overflow_o
);

  logic [LOG_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  free_cnt;

  logic pop_eff;
  logic push_acc;
  logic push_rej;
  logic mem_we;

  // Status flags come from the count register alone, so the commit stage sees
  // no combinational path from push_i or pop_i.
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign free_cnt      = CNT_W'(DEPTH) - count_q;
  assign almost_full_o = (32'(free_cnt) <= 32'(AF_SLACK));
  assign usage_o       = count_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign overflow_o    = overflow_q;

  // Show-ahead head: only moves when rd_ptr advances on an effective pop.
  assign log_o = mem_q[rd_ptr_q];

  // Next-state: pointer and count updates, drop accounting, flush clearing.
  always_comb begin
    // NOTE: every _d defaults to its _q first so no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    pop_eff  = pop_i & ~empty_o;
    push_acc = push_i & (~full_o | pop_eff);
    push_rej = push_i & full_o & ~pop_eff;
    mem_we   = push_acc & ~flush_i;

    if (flush_i) begin
      // Flush wins over push/pop in the same cycle; drop history is kept.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_acc, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push_rej) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; the count makes stale entries invisible.
    if (mem_we) mem_q[wr_ptr_q] <= log_i;
  end

endmodule
